alu_mc: RTL and testbench

Multi-cycle, parametrised execute-stage ALU for the rv32i core. It performs all base integer operations with a registered single-cycle result, plus RV32M multiply/divide/remainder through an iterative shift-add / restoring-divide engine. It sits between the ID/EX pipeline register and the EX/MEM register. The hazard unit stalls the pipeline while `in_ready` is low.

---
 rtl/alu_mc_pkg.sv | 47 ++++
 rtl/alu_mc_iter.sv | 134 +++++++++++++
 rtl/alu_mc.sv | 165 ++++++++++++++++
 tb/tb_alu_mc.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types and constants for the alu_mc execute-stage ALU.
//   alu_op_e    - 5-bit operation codes presented on `Operation`
//   alu_state_e - control FSM states (DIV only when ALU_MC_DIV_EN is defined)
//   XLEN        - default operand width, SHAMT_W its shift-amount width
// Configuration macro: ALU_MC_DIV_EN enables the divide/remainder engine.
package alu_mc_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [4:0] {
        OP_AND    = 5'd0,
        OP_OR     = 5'd1,
        OP_ADD    = 5'd2,
        OP_XOR    = 5'd3,
        OP_SLL    = 5'd4,
        OP_SRL    = 5'd5,
        OP_SUB    = 5'd6,
        OP_SRA    = 5'd7,
        OP_EQ     = 5'd8,
        OP_NE     = 5'd9,
        OP_GE     = 5'd10,
        OP_LT     = 5'd11,
        OP_LTU    = 5'd12,
        OP_GEU    = 5'd13,
        OP_PASSB  = 5'd14,
        OP_ONE    = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative multiply (shift-add) and divide (restoring) engine.
// Ports:
//   clk, reset  - clock, synchronous active-low reset (discards any operation)
//   start       - load operands and begin DATA_WIDTH steps
//   is_div      - op class: 1 = divide/remainder, 0 = multiply
//                 (port exists only when ALU_MC_DIV_EN is defined)
//   sub_op      - Operation[1:0]: MUL/MULH/MULHSU/MULHU or DIV/DIVU/REM/REMU
//   a, b        - operands, sampled only on start
//   done        - high during the cycle whose rising edge completes the last step
//   result      - sign-corrected result, valid while done is high
// Configuration macro: ALU_MC_DIV_EN adds the divider datapath.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef ALU_MC_DIV_EN
    input  logic                  is_div,
`endif
    input  logic [1:0]            sub_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic                    running;
    logic [CW-1:0]           cnt;
    // hi: product high half / partial remainder; lo: multiplier / quotient
    logic [DATA_WIDTH-1:0]   hi, lo, mag_b;
    logic                    neg, sel_hi;

    logic                    a_signed, b_signed, sa, sb;
    logic [DATA_WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH-1:0]   nx_hi, nx_lo;
    logic [2*DATA_WIDTH-1:0] prod, prod_fix;

`ifdef ALU_MC_DIV_EN
    logic                    div_mode;
    logic [DATA_WIDTH:0]     rem_sh, rem_sub;
    logic                    div_ge;
`endif

    // Operand sign/magnitude conversion at start.
    always_comb begin
        a_signed = (sub_op == 2'd1) || (sub_op == 2'd2);
        b_signed = (sub_op == 2'd1);
`ifdef ALU_MC_DIV_EN
        if (is_div) begin
            a_signed = !sub_op[0];
            b_signed = !sub_op[0];
        end
`endif
        sa       = a_signed && a[DATA_WIDTH-1];
        sb       = b_signed && b[DATA_WIDTH-1];
        mag_a_in = sa ? -a : a;
        mag_b_in = sb ? -b : b;
    end

    // One step, plus the sign fix-up applied to the post-step value so the
    // final result is ready on the same edge as the last step.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
        nx_hi   = mul_sum[DATA_WIDTH:1];
        nx_lo   = {mul_sum[0], lo[DATA_WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        // Partial remainder stays below the divisor, so DATA_WIDTH+1 bits suffice.
        rem_sh  = {hi, lo[DATA_WIDTH-1]};
        rem_sub = rem_sh - {1'b0, mag_b};
        div_ge  = rem_sh >= {1'b0, mag_b};
        if (div_mode) begin
            nx_hi = div_ge ? rem_sub[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
            nx_lo = {lo[DATA_WIDTH-2:0], div_ge};
        end
`endif
        // Products are negated as a full double-width value so the high half
        // picks up the borrow from the low half.
        prod     = {nx_hi, nx_lo};
        prod_fix = neg ? -prod : prod;
        result   = sel_hi ? prod_fix[2*DATA_WIDTH-1:DATA_WIDTH] : prod_fix[DATA_WIDTH-1:0];
`ifdef ALU_MC_DIV_EN
        if (div_mode) begin
            result = sel_hi ? (neg ? -nx_hi : nx_hi) : (neg ? -nx_lo : nx_lo);
        end
`endif
    end

    assign done = running && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            running  <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mag_b    <= '0;
            neg      <= 1'b0;
            sel_hi   <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_mode <= 1'b0;
`endif
        end else if (start) begin
            running  <= 1'b1;
            cnt      <= '0;
            hi       <= '0;
            lo       <= mag_a_in;
            mag_b    <= mag_b_in;
`ifdef ALU_MC_DIV_EN
            div_mode <= is_div;
            // Remainder takes the dividend's sign, quotient/product sA^sB.
            neg      <= (is_div && sub_op[1]) ? sa : (sa ^ sb);
            sel_hi   <= is_div ? sub_op[1] : (sub_op != 2'd0);
`else
            neg      <= sa ^ sb;
            sel_hi   <= (sub_op != 2'd0);
`endif
        end else if (running) begin
            hi  <= nx_hi;
            lo  <= nx_lo;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU (base integer ops in one cycle,
// RV32M multiply/divide through alu_mc_iter).
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   in_valid / in_ready - operand handshake; accept when both are high
//   SrcA, SrcB          - operands, latched only at accept
//   Operation           - alu_op_e code
//   out_valid/out_ready - result handshake; ALUResult held until taken
//   ALUResult           - registered result
//   busy                - iterative op in progress
//   fsm_state           - current control state (alu_state_e encoding)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised, holds with its data until that edge, and
// inputs offered while not ready are ignored.
// Configuration macro: ALU_MC_DIV_EN enables DIV/DIVU/REM/REMU; otherwise
// codes 20-23 behave like unused codes (result 0, one cycle).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH    = XLEN,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy,
    output logic [1:0]               fsm_state
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    alu_state_e            state;
    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] quick_result, iter_result;
    logic                  is_mul, iter_start, iter_done;
    logic                  eq, lt_s, lt_u;

    assign shamt  = SrcB[SHW-1:0];
    assign eq     = (SrcA == SrcB);
    assign lt_s   = ($signed(SrcA) < $signed(SrcB));
    assign lt_u   = (SrcA < SrcB);
    assign is_mul = (Operation >= OP_MUL) && (Operation <= OP_MULHU);

`ifdef ALU_MC_DIV_EN
    logic is_div, div_zero, div_ovf, div_special;
    assign is_div      = (Operation >= OP_DIV) && (Operation <= OP_REMU);
    assign div_zero    = (SrcB == '0);
    // Only the signed forms (bit 0 clear) can overflow.
    assign div_ovf     = !Operation[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    assign div_special = div_zero || div_ovf;
    assign iter_start  = (state == S_IDLE) && in_valid && (is_mul || (is_div && !div_special));
`else
    assign iter_start  = (state == S_IDLE) && in_valid && is_mul;
`endif

    always_comb begin
        quick_result = '0;
        case (Operation)
            OP_AND:   quick_result = SrcA & SrcB;
            OP_OR:    quick_result = SrcA | SrcB;
            OP_ADD:   quick_result = SrcA + SrcB;
            OP_XOR:   quick_result = SrcA ^ SrcB;
            OP_SLL:   quick_result = SrcA << shamt;
            OP_SRL:   quick_result = SrcA >> shamt;
            OP_SUB:   quick_result = SrcA - SrcB;
            OP_SRA:   quick_result = $signed(SrcA) >>> shamt;
            OP_EQ:    quick_result = {{(DATA_WIDTH-1){1'b0}}, eq};
            OP_NE:    quick_result = {{(DATA_WIDTH-1){1'b0}}, !eq};
            OP_GE:    quick_result = {{(DATA_WIDTH-1){1'b0}}, !lt_s};
            OP_LT:    quick_result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            OP_LTU:   quick_result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            OP_GEU:   quick_result = {{(DATA_WIDTH-1){1'b0}}, !lt_u};
            OP_PASSB: quick_result = SrcB;
            OP_ONE:   quick_result = DATA_WIDTH'(1);
`ifdef ALU_MC_DIV_EN
            // Only reached for the special cases; normal divides go iterative.
            OP_DIV, OP_DIVU: quick_result = div_zero ? '1 : MIN_NEG;
            OP_REM, OP_REMU: quick_result = div_zero ? SrcA : '0;
`endif
            default:  quick_result = '0;
        endcase
    end

    alu_mc_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
`ifdef ALU_MC_DIV_EN
        .is_div (is_div),
`endif
        .sub_op (Operation[1:0]),
        .a      (SrcA),
        .b      (SrcB),
        .done   (iter_done),
        .result (iter_result)
    );

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            ALUResult <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (iter_start) begin
                            busy  <= 1'b1;
`ifdef ALU_MC_DIV_EN
                            state <= is_div ? S_DIV : S_MUL;
`else
                            state <= S_MUL;
`endif
                        end else begin
                            ALUResult <= quick_result;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
`ifdef ALU_MC_DIV_EN
                S_MUL, S_DIV: begin
`else
                S_MUL: begin
`endif
                    if (iter_done) begin
                        ALUResult <= iter_result;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (DATA_WIDTH = 32).
// Expected results come from a behavioural model using 64-bit arithmetic and
// the language's / and % operators; a monitor compares DUT outputs against a
// queue of expectations pushed at accept time. Honours ALU_MC_DIV_EN.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [4:0]   Operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         busy;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];

    bit stall_out  = 1'b0;
    bit rand_ready = 1'b0;

    alu_mc #(
        .DATA_WIDTH    (W),
        .OPCODE_LENGTH (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [W-1:0] as_, bs_;
        logic signed [63:0]  a64s, b64s, b64u, ps;
        logic [63:0]         pu;
        logic [4:0]          sh;
        as_  = a;
        bs_  = b;
        a64s = as_;
        b64s = bs_;
        b64u = {32'd0, b};
        pu   = {32'd0, a} * {32'd0, b};
        sh   = b[4:0];
        case (op)
            5'd0:  return a & b;
            5'd1:  return a | b;
            5'd2:  return a + b;
            5'd3:  return a ^ b;
            5'd4:  return a << sh;
            5'd5:  return a >> sh;
            5'd6:  return a - b;
            5'd7:  return as_ >>> sh;
            5'd8:  return (a == b) ? 32'd1 : 32'd0;
            5'd9:  return (a != b) ? 32'd1 : 32'd0;
            5'd10: return (as_ >= bs_) ? 32'd1 : 32'd0;
            5'd11: return (as_ < bs_) ? 32'd1 : 32'd0;
            5'd12: return (a < b) ? 32'd1 : 32'd0;
            5'd13: return (a >= b) ? 32'd1 : 32'd0;
            5'd14: return b;
            5'd15: return 32'd1;
            5'd16: return pu[31:0];
            5'd17: begin ps = a64s * b64s; return ps[63:32]; end
            5'd18: begin ps = a64s * b64u; return ps[63:32]; end
            5'd19: return pu[63:32];
`ifdef ALU_MC_DIV_EN
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return as_ / bs_;
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return as_ % bs_;
            end
            5'd23: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        if (op >= 5'd16 && op <= 5'd19) return W + 1;
`ifdef ALU_MC_DIV_EN
        if (op >= 5'd20 && op <= 5'd23) begin
            if (b == 0) return 1;
            if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return W + 1;
        end
`endif
        return 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int   waited;
        logic rdy;
        waited = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy) begin
                exp_q.push_back(model(op, a, b));
                lat_q.push_back(model_lat(op, a, b));
                acc_q.push_back(cyc + 1);
            end
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
                break;
            end
        end
        // Scramble inputs after accept; the DUT must not re-sample them.
        in_valid  = 1'b0;
        Operation = 5'($urandom_range(0, 31));
        SrcA      = $urandom();
        SrcB      = $urandom();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        #1;
    endtask

    initial begin : ready_driver
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_out)       out_ready = 1'b0;
            else if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            else                 out_ready = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        bit have_first;
        bit just_consumed;
        int busy_cnt;
        int exp_busy;
        have_first    = 1'b0;
        just_consumed = 1'b0;
        busy_cnt      = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                have_first    = 1'b0;
                just_consumed = 1'b0;
                busy_cnt      = 0;
                continue;
            end
            if (just_consumed) begin
                check("in_ready_after_consume", 32'(in_ready), 32'd1);
                check("out_valid_after_consume", 32'(out_valid), 32'd0);
                just_consumed = 1'b0;
            end
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_valid=1 result %h expected no output", ALUResult);
                end else begin
                    if (!have_first) begin
                        check("latency", 32'(cyc - acc_q[0] + 1), 32'(lat_q[0]));
                        exp_busy = (lat_q[0] == 1) ? 0 : lat_q[0] - 1;
                        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
                        busy_cnt   = 0;
                        have_first = 1'b1;
                    end
                    check("result", ALUResult, exp_q[0]);
                    check("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                        have_first    = 1'b0;
                        just_consumed = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int n;
        logic [4:0] op;
        reset     = 1'b0;
        in_valid  = 1'b0;
        Operation = '0;
        SrcA      = '0;
        SrcB      = '0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Directed cases
        issue(5'd2,  32'hFFFF_FFFF, 32'h0000_0001);   // ADD wraps to 0
        issue(5'd7,  32'h8000_0000, 32'd4);           // SRA
        issue(5'd12, 32'd1, 32'hFFFF_FFFF);           // LTU
        issue(5'd6,  32'd5, 32'd9);                   // SUB
        issue(5'd4,  32'h0000_00F1, 32'hFFFF_FFE4);   // SLL uses low 5 bits
        issue(5'd10, 32'hFFFF_FFFF, 32'd1);           // GE signed
        issue(5'd14, 32'd7, 32'h1234_5000);           // PASSB
        issue(5'd15, 32'd7, 32'd8);                   // ONE
        issue(5'd31, 32'd7, 32'd8);                   // unused code
        issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // MULH
        issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // MULHU
        issue(5'd18, 32'hFFFF_FFFE, 32'd3);           // MULHSU
        issue(5'd16, 32'd3, 32'd5);                   // MUL
        issue(5'd20, 32'hFFFF_FFF9, 32'd2);           // DIV -7/2
        issue(5'd22, 32'hFFFF_FFF9, 32'd2);           // REM -7/2
        issue(5'd21, 32'd100, 32'd0);                 // DIVU by zero
        issue(5'd23, 32'd100, 32'd0);                 // REMU by zero
        issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF);   // DIV overflow
        issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF);   // REM overflow
        issue(5'd20, 32'd10, 32'd2);                  // DIV 10/2
        wait_drain();

        // Backpressure: result held, in_ready low, extra request ignored.
        stall_out = 1'b1;
        issue(5'd2, 32'd5, 32'd7);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        Operation = 5'd1;
        SrcA      = 32'hA5A5_0000;
        SrcB      = 32'h0000_5A5A;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", ALUResult, 32'd12);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        stall_out = 1'b0;
        wait_drain();

        // Reset in the middle of a multiply: op discarded, no stale result.
        issue(5'd16, 32'd1234, 32'd5678);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", ALUResult, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // Randomized traffic with random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom_range(0, 31));
            issue(op, pick(), pick());
        end
        wait_drain();
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
